// File: rtl/alu_mc_pkg.sv
// Shared funct encodings, FSM state type and decode helpers for the multi-cycle ALU.
// Base codes keep their original values; the M extension occupies 16..23 in RISC-V funct3 order.
package alu_mc_pkg;

  localparam int ALU_FUNCT_WIDTH = 5;

  typedef logic [ALU_FUNCT_WIDTH-1:0] funct_t;

  localparam funct_t FN_AND    = 5'd0;
  localparam funct_t FN_OR     = 5'd1;
  localparam funct_t FN_XOR    = 5'd2;
  localparam funct_t FN_NOR    = 5'd3;
  localparam funct_t FN_SLT    = 5'd4;
  localparam funct_t FN_SLTU   = 5'd5;
  localparam funct_t FN_SLL    = 5'd6;
  localparam funct_t FN_SRL    = 5'd7;
  localparam funct_t FN_SRA    = 5'd8;
  localparam funct_t FN_ADD    = 5'd9;
  localparam funct_t FN_SUB    = 5'd10;
  localparam funct_t FN_MUL    = 5'd16;
  localparam funct_t FN_MULH   = 5'd17;
  localparam funct_t FN_MULHSU = 5'd18;
  localparam funct_t FN_MULHU  = 5'd19;
  localparam funct_t FN_DIV    = 5'd20;
  localparam funct_t FN_DIVU   = 5'd21;
  localparam funct_t FN_REM    = 5'd22;
  localparam funct_t FN_REMU   = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input funct_t f);
    return f[4:3] == 2'b10;
  endfunction

  function automatic logic is_div(input funct_t f);
    return f[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide datapath: magnitude load, N shift-add or
// restoring-subtract steps, and a combinational sign fix-up of the final value.
module alu_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int N = 32,
  localparam int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         step,
  input  funct_t       funct,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         last,
  output logic [N-1:0] result
);

  logic [N-1:0]   hi;
  logic [N-1:0]   lo;
  logic [N-1:0]   opb;
  logic [SHW-1:0] count;
  logic           div_op;
  logic           sel_hi;
  logic           sel_rem;
  logic           neg_res;

  logic           a_sgn;
  logic           b_sgn;
  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [N:0]     sum;
  logic [N:0]     shifted;
  logic [N:0]     diff;
  logic [2*N-1:0] prod;
  logic [N-1:0]   qr;

  always_comb begin
    a_sgn = is_div(funct) ? !funct[0] : (funct[1:0] == 2'b01 || funct[1:0] == 2'b10);
    b_sgn = is_div(funct) ? !funct[0] : (funct[1:0] == 2'b01);
    a_neg = a_sgn && x[N-1];
    b_neg = b_sgn && y[N-1];
    mag_a = a_neg ? -x : x;
    mag_b = b_neg ? -y : y;
  end

  // Multiply keeps {hi,lo} as the running product with the multiplier shifting out of lo;
  // divide keeps the partial remainder in hi and grows the quotient into lo.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(N+1){1'b0}});
    shifted = {hi, lo[N-1]};
    diff    = shifted - {1'b0, opb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      count   <= '0;
      div_op  <= 1'b0;
      sel_hi  <= 1'b0;
      sel_rem <= 1'b0;
      neg_res <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      hi      <= '0;
      lo      <= mag_a;
      opb     <= mag_b;
      count   <= '0;
      div_op  <= is_div(funct);
      sel_hi  <= !is_div(funct) && (funct[1:0] != 2'b00);
      sel_rem <= funct[1];
      neg_res <= (is_div(funct) && funct[1]) ? a_neg : (a_neg ^ b_neg);
    end else if (step) begin
      count <= count + 1'b1;
      if (div_op) begin
        if (!diff[N]) begin
          hi <= diff[N-1:0];
          lo <= {lo[N-2:0], 1'b1};
        end else begin
          hi <= shifted[N-1:0];
          lo <= {lo[N-2:0], 1'b0};
        end
      end else begin
        hi <= sum[N:1];
        lo <= {sum[0], lo[N-1:1]};
      end
    end
  end

  assign last = &count;

  always_comb begin
    prod   = neg_res ? -{hi, lo} : {hi, lo};
    qr     = sel_rem ? hi : lo;
    result = '0;
    if (div_op) result = neg_res ? -qr : qr;
    else        result = sel_hi ? prod[2*N-1:N] : prod[N-1:0];
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base functions and fast-path divide cases, plus
// RV32M multiply/divide on the shared iterative datapath, with registered results.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int N = 32,
  localparam int SHW = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  input  logic [ALU_FUNCT_WIDTH-1:0] funct,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               z,
  output logic                       equal,
  output logic                       zero,
  output logic                       overflow,
  output logic                       div_zero
);

  state_t       state;
  state_t       state_n;
  logic         accept;
  logic         load;
  logic         step;
  logic         iter_op;
  logic         fast;
  logic         y_zero;
  logic         min_by_neg1;
  logic         iter_last;
  logic [N-1:0] iter_z;
  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic [N-1:0] base_z;
  logic         base_ov;
  logic         base_dz;
  logic         base_def;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready depends only on state and out_ready, and flush cancels any transfer that cycle.
  assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  assign y_zero      = ~|y;
  assign min_by_neg1 = !funct[0] && (x == {1'b1, {(N-1){1'b0}}}) && (&y);
  assign fast        = is_div(funct) && (y_zero || min_by_neg1);
  assign iter_op     = is_muldiv(funct) && !fast;

  always_comb begin
    state_n = state;
    step    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_n = iter_op ? ST_BUSY : ST_DONE;
        else if (state == ST_DONE && out_ready) state_n = ST_IDLE;
      end
      ST_BUSY: begin
        step = 1'b1;
        if (iter_last) state_n = ST_FIX;
      end
      ST_FIX:  state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) begin
      state_n = ST_IDLE;
      step    = 1'b0;
    end
  end

  assign load = accept && iter_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Fast-path divide entries are only consumed when fast is set; MIN / -1 returns x itself.
  always_comb begin
    sum      = x + y;
    diff     = x - y;
    base_z   = '0;
    base_ov  = 1'b0;
    base_dz  = 1'b0;
    base_def = 1'b1;
    case (funct)
      FN_AND:  base_z = x & y;
      FN_OR:   base_z = x | y;
      FN_XOR:  base_z = x ^ y;
      FN_NOR:  base_z = ~(x | y);
      FN_SLT:  base_z = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
      FN_SLTU: base_z = {{(N-1){1'b0}}, (x < y)};
      FN_SLL:  base_z = x << y[SHW-1:0];
      FN_SRL:  base_z = x >> y[SHW-1:0];
      FN_SRA:  base_z = $unsigned($signed(x) >>> y[SHW-1:0]);
      FN_ADD: begin
        base_z  = sum;
        base_ov = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
      end
      FN_SUB: begin
        base_z  = diff;
        base_ov = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
      end
      FN_DIV: begin
        base_z  = y_zero ? '1 : x;
        base_dz = y_zero;
        base_ov = !y_zero;
      end
      FN_DIVU: begin
        base_z  = '1;
        base_dz = y_zero;
      end
      FN_REM, FN_REMU: begin
        base_z  = y_zero ? x : '0;
        base_dz = y_zero;
      end
      default: base_def = 1'b0;
    endcase
  end

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .load   (load),
    .step   (step),
    .funct  (funct),
    .x      (x),
    .y      (y),
    .last   (iter_last),
    .result (iter_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
      equal     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= (state_n == ST_DONE);
      if (accept) equal <= (iter_op || base_def) && (x == y);
      if (accept && !iter_op) begin
        z        <= base_z;
        zero     <= base_def && (base_z == '0);
        overflow <= base_ov;
        div_zero <= base_dz;
      end else if (state == ST_FIX && !flush) begin
        z        <= iter_z;
        zero     <= (iter_z == '0);
        overflow <= 1'b0;
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: issued ops push expected {z,equal,zero,overflow,div_zero}
// and latency into queues; a monitor pops and compares whenever a result is taken.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int N = 32;
  localparam int W = N + 4;
  // Cycles from the accept edge (counted as 1) to the first cycle out_valid is seen.
  localparam int LAT_BASE = 1;
  localparam int LAT_ITER = N + 2;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  funct_t       funct;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;
  logic         equal;
  logic         zero;
  logic         overflow;
  logic         div_zero;

  alu_mc #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .equal     (equal),
    .zero      (zero),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           lat_q[$];
  string        name_q[$];
  bit           seen = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // driver
  task automatic issue(input string nm, input funct_t f, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] ez, input logic eeq, input logic ezr, input logic eov,
                       input logic edz, input int elat, input bit track);
    int  waited = 0;
    bit  done = 1'b0;
    funct    = f;
    x        = a;
    y        = b;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        done = 1'b1;
        if (track) begin
          exp_q.push_back({ez, eeq, ezr, eov, edz});
          acc_q.push_back(cyc + 1);
          lat_q.push_back(elat);
          name_q.push_back(nm);
        end
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout %s actual=not accepted required=accepted", nm);
          done = 1'b1;
        end
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
      lat_q.delete();
      name_q.delete();
      seen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {63'd0, out_valid}, 64'd0);
      end else begin
        if (!seen) begin
          check({"latency ", name_q[0]}, 64'(cyc - acc_q[0] + 1), 64'(lat_q[0]));
          seen = 1'b1;
        end
        if (out_ready) begin
          check({"result ", name_q[0]}, 64'({z, equal, zero, overflow, div_zero}), 64'(exp_q[0]));
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          void'(lat_q.pop_front());
          void'(name_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    funct     = FN_AND;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_outputs", 64'({z, equal, zero, overflow, div_zero}), 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // base ops
    issue("ADD ovf",  FN_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0, 1, 0, LAT_BASE, 1);
    issue("SUB eq",   FN_SUB,  32'h5,        32'h5,        32'h0,        1, 1, 0, 0, LAT_BASE, 1);
    issue("SUB ovf",  FN_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 0, 1, 0, LAT_BASE, 1);
    issue("AND",      FN_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, LAT_BASE, 1);
    issue("OR",       FN_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 0, LAT_BASE, 1);
    issue("XOR",      FN_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, LAT_BASE, 1);
    issue("NOR",      FN_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0, 0, LAT_BASE, 1);
    issue("SLT",      FN_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 0, LAT_BASE, 1);
    issue("SLTU",     FN_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1, 0, 0, LAT_BASE, 1);
    issue("SLL",      FN_SLL,  32'h1,        32'h24,       32'h10,       0, 0, 0, 0, LAT_BASE, 1);
    issue("SRL",      FN_SRL,  32'h80000000, 32'h1F,       32'h1,        0, 0, 0, 0, LAT_BASE, 1);
    issue("SRA",      FN_SRA,  32'h80000000, 32'h21,       32'hC0000000, 0, 0, 0, 0, LAT_BASE, 1);
    issue("UNDEF",    5'd11,   32'h3,        32'h3,        32'h0,        0, 0, 0, 0, LAT_BASE, 1);

    // iterative multiply / divide
    issue("MUL ff",   FN_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1, 0, 0, 0, LAT_ITER, 1);
    issue("MULHU ff", FN_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 0, LAT_ITER, 1);
    issue("MULH ff",  FN_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 0, LAT_ITER, 1);
    issue("MULHSU",   FN_MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, 0, 0, 0, LAT_ITER, 1);
    issue("MUL 3x5",  FN_MUL,    32'h3,        32'h5,        32'hF,        0, 0, 0, 0, LAT_ITER, 1);
    issue("DIV -7/2", FN_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, 0, 0, 0, LAT_ITER, 1);
    issue("REM -7/2", FN_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, 0, 0, 0, LAT_ITER, 1);
    issue("DIV 7/-2", FN_DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 0, 0, LAT_ITER, 1);
    issue("REM 7/-2", FN_REM,    32'h7,        32'hFFFFFFFE, 32'h1,        0, 0, 0, 0, LAT_ITER, 1);
    issue("DIVU",     FN_DIVU,   32'd100,      32'd7,        32'd14,       0, 0, 0, 0, LAT_ITER, 1);
    issue("REMU",     FN_REMU,   32'd100,      32'd7,        32'd2,        0, 0, 0, 0, LAT_ITER, 1);

    // fast-path divide cases
    issue("DIVU /0",  FN_DIVU, 32'h5,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 1, LAT_BASE, 1);
    issue("REMU /0",  FN_REMU, 32'h5,        32'h0,        32'h5,        0, 0, 0, 1, LAT_BASE, 1);
    issue("REM /0",   FN_REM,  32'h7,        32'h0,        32'h7,        0, 0, 0, 1, LAT_BASE, 1);
    issue("DIV 0/0",  FN_DIV,  32'h0,        32'h0,        32'hFFFFFFFF, 1, 0, 0, 1, LAT_BASE, 1);
    issue("DIV min",  FN_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 1, 0, LAT_BASE, 1);
    issue("REM min",  FN_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 1, 0, 0, LAT_BASE, 1);
    wait_drain();

    // back-to-back base ops, one accept per edge
    e0 = cyc;
    issue("B2B 1", FN_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0, LAT_BASE, 1);
    issue("B2B 2", FN_ADD, 32'd4, 32'd5, 32'd9, 0, 0, 0, 0, LAT_BASE, 1);
    issue("B2B 3", FN_XOR, 32'd6, 32'd6, 32'd0, 1, 1, 0, 0, LAT_BASE, 1);
    check("b2b_edges", 64'(cyc - e0), 64'd3);
    wait_drain();

    // consumer stall in DONE
    out_ready = 1'b0;
    issue("stall ADD", FN_ADD, 32'd10, 32'd20, 32'd30, 0, 0, 0, 0, LAT_BASE, 1);
    fork
      issue("after stall", FN_XOR, 32'hFF, 32'h0F, 32'hF0, 0, 0, 0, 0, LAT_BASE, 1);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("stall_hold", 64'({out_valid, z, equal, zero, overflow, div_zero}), {27'd0, 1'b1, 32'd30, 4'b0000});
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("ready_rise_in_ready", {63'd0, in_ready}, 64'd1);
      end
    join
    wait_drain();

    // flush in the tenth BUSY cycle
    issue("kill flush", FN_MUL, 32'd3, 32'd5, 32'd0, 0, 0, 0, 0, LAT_ITER, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_idle", {63'd0, in_ready}, 64'd1);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    issue("ADD post flush", FN_ADD, 32'd100, 32'd23, 32'd123, 0, 0, 0, 0, LAT_BASE, 1);
    wait_drain();

    // reset in the twentieth BUSY cycle
    issue("kill reset", FN_DIVU, 32'd1000, 32'd3, 32'd0, 0, 0, 0, 0, LAT_ITER, 0);
    repeat (19) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("reset_busy_idle", {63'd0, in_ready}, 64'd1);
    check("reset_busy_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_busy_z", 64'(z), 64'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue("ADD post reset", FN_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 1, 0, 0, LAT_BASE, 1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
